// File: rtl/restador_serial_16bits_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : restador_serial_16bits_pkg                                    |
// | Description: Shared state encoding and sizing for the bit-serial subtractor|
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package restador_serial_16bits_pkg;

  localparam int c_WIDTH = 16;
  localparam int c_CNT_W = $clog2(c_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/restador_serial_16bits_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : restador_serial_16bits_if                                     |
// | Description: Operand/result valid-ready bus of the bit-serial subtractor   |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface restador_serial_16bits_if
  import restador_serial_16bits_pkg::*;
#(
  parameter int WIDTH = c_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             borrow_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] DIFF;
  logic             borrow_out;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, A, B, borrow_in, out_ready,
    input  in_ready, out_valid, DIFF, borrow_out, zero, ovf
  );

  modport slave (
    input  in_valid, A, B, borrow_in, out_ready,
    output in_ready, out_valid, DIFF, borrow_out, zero, ovf
  );
endinterface
`default_nettype wire

// File: rtl/restador_completo_1bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : restador_completo_1bit                                        |
// | Description: Combinational 1-bit full subtractor (a - b - bin)             |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module restador_completo_1bit (
  input  wire logic a,
  input  wire logic b,
  input  wire logic bin,
  output logic      d,
  output logic      bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule
`default_nettype wire

// File: rtl/restador_serial_16bits.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : restador_serial_16bits                                        |
// | Description: Bit-serial subtractor DIFF = A - B - borrow_in, LSB first     |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module restador_serial_16bits
  import restador_serial_16bits_pkg::*;
#(
  parameter int WIDTH = c_WIDTH
) (
  input  wire logic                clk,
  input  wire logic                rst,
  restador_serial_16bits_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_br;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_zero;
  logic             r_ovf;

  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic             w_in_ready;
  logic             w_out_valid;
  logic [WIDTH-1:0] w_res_shift;

  restador_completo_1bit u_cell (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
  // New bit enters from the MSB side; on the last bit this is the full result.
  assign w_res_shift = {w_d, r_res};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_cnt  <= '0;
      r_br   <= 1'b0;
      r_diff <= '0;
      r_bout <= 1'b0;
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && bus.in_valid) begin
        r_a   <= bus.A;
        r_b   <= bus.B;
        r_br  <= bus.borrow_in;
        r_cnt <= '0;
      end else if (r_state == ST_RUN) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_br  <= w_bout;
        r_res <= w_res_shift[WIDTH-1:1];
        r_cnt <= r_cnt + 1'b1;
        // Last bit: r_a[0]/r_b[0] are the operand MSBs, w_d is the result MSB.
        if (w_last) begin
          r_diff <= w_res_shift;
          r_bout <= w_bout;
          r_zero <= (w_res_shift == '0);
          r_ovf  <= (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
        end
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.DIFF       = r_diff;
  assign bus.borrow_out = r_bout;
  assign bus.zero       = r_zero;
  assign bus.ovf        = r_ovf;

endmodule
`default_nettype wire
